// File: rtl/divided_clock_timer.sv
// divided_clock_timer: synchronises a slow divided clock into clk_FPGA, turns its rising edges
// into single-cycle ticks, and runs a one-shot/periodic down-counter on those ticks.
module divided_clock_timer #(
    parameter int SYNC_STAGES = 2,
    parameter int NBITS_COUNT = 16
) (
    input  logic                   clk_FPGA,
    input  logic                   reset,
    input  logic                   slow_clock,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   periodic,
    input  logic [NBITS_COUNT-1:0] load_value,
    output logic                   tick,
    output logic [NBITS_COUNT-1:0] count,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, RUN, EXPIRE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d, tick_q, tick_d;
    logic [NBITS_COUNT-1:0] count_q, count_d, reload_q, reload_d;
    logic                   periodic_q, periodic_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], slow_clock};
        prev_d = sync_q[SYNC_STAGES-1];
        tick_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // A start carrying a zero load value is never accepted, whatever the state.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        periodic_d = periodic_q;
        if (stop) begin
            state_d = IDLE;
        end else if (start && load_value != '0) begin
            state_d    = RUN;
            count_d    = load_value;
            reload_d   = load_value;
            periodic_d = periodic;
        end else begin
            case (state_q)
                RUN: if (tick_q) begin
                    count_d = count_q > NBITS_COUNT'(1) ? count_q - 1'b1 : '0;
                    state_d = count_q > NBITS_COUNT'(1) ? RUN : EXPIRE;
                end
                EXPIRE: begin
                    state_d = periodic_q ? RUN : IDLE;
                    count_d = periodic_q ? reload_q : count_q;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = state_d != IDLE;
        done_d = state_d == EXPIRE;
    end

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            tick_q     <= 1'b0;
            count_q    <= '0;
            reload_q   <= '0;
            periodic_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            tick_q     <= tick_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            periodic_q <= periodic_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tick  = tick_q;
    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_divided_clock_timer.sv
// tb_divided_clock_timer: directed table, corner sequences and random stimulus against a
// tick-history / ticks-remaining reference model of the timer.
module tb_divided_clock_timer;
    localparam int S = 2;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         slow_clock = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         periodic = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         tick, busy, done;
    logic [W-1:0] count;

    divided_clock_timer #(.SYNC_STAGES(S), .NBITS_COUNT(W)) dut (
        .clk_FPGA(clk), .reset(reset), .slow_clock(slow_clock), .start(start), .stop(stop),
        .periodic(periodic), .load_value(load_value), .tick(tick), .count(count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, n_done = 0, n_tick = 0;
    bit rst_v = 1'b0;

    // Reference model: mode 0=idle, 1=running, 2=expired this cycle
    bit   hist[$];
    bit   m_tick;
    int   m_mode, m_cnt, m_rel;
    bit   m_per;

    typedef struct {
        bit st, sp, per;
        int ld, periods, exp_cnt;
        bit exp_busy;
        int exp_dones;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist = '{};
        repeat (S + 2) hist.push_back(1'b0);
        m_tick = 0; m_mode = 0; m_cnt = 0; m_rel = 0; m_per = 0;
    endtask

    task automatic model_step();
        bit old_tick;
        if (!reset) begin
            model_reset();
            return;
        end
        old_tick = m_tick;
        hist.push_back(slow_clock);
        if (hist.size() > 8) void'(hist.pop_front());
        m_tick = hist[hist.size()-1-S] && !hist[hist.size()-2-S];
        if (stop) m_mode = 0;
        else if (start && load_value != 0) begin
            m_cnt = int'(load_value); m_rel = int'(load_value); m_per = periodic; m_mode = 1;
        end else if (m_mode == 2) begin
            if (m_per) begin m_cnt = m_rel; m_mode = 1; end
            else m_mode = 0;
        end else if (m_mode == 1 && old_tick) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_mode = 2;
        end
    endtask

    task automatic cyc(input bit st, input bit sp, input bit per, input int ld, input bit sl);
        @(negedge clk);
        reset = rst_v; start = st; stop = sp; periodic = per; load_value = W'(ld); slow_clock = sl;
        @(posedge clk);
        model_step();
        #1;
        chk("tick", int'(tick), int'(m_tick));
        chk("count", int'(count), m_cnt);
        chk("busy", int'(busy), int'(m_mode != 0));
        chk("done", int'(done), int'(m_mode == 2));
        if (done) n_done++;
        if (tick) n_tick++;
    endtask

    task automatic period(input int n);
        repeat (n) begin
            repeat (10) cyc(0, 0, 0, 0, 1);
            repeat (10) cyc(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        int first, ph_left;
        bit sl;
        tbl[0] = '{1, 0, 0, 3, 2, 1, 1, 0};
        tbl[1] = '{0, 0, 0, 0, 1, 0, 0, 1};
        tbl[2] = '{1, 0, 1, 2, 6, 2, 1, 3};
        tbl[3] = '{1, 0, 0, 5, 0, 5, 1, 0};
        tbl[4] = '{1, 1, 0, 9, 0, 5, 0, 0};
        tbl[5] = '{1, 0, 0, 0, 0, 5, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 2, 5, 0, 0};
        model_reset();

        rst_v = 0;
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("reset_count", int'(count), 0);
        chk("reset_busy", int'(busy), 0);
        rst_v = 1;
        repeat (3) cyc(0, 0, 0, 0, 0);

        first = 0; n_tick = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 0, 0, 1);
            if (tick && first == 0) first = i;
        end
        repeat (10) cyc(0, 0, 0, 0, 0);
        chk("tick_latency", first, S + 1);
        chk("ticks_per_period", n_tick, 1);

        for (int i = 0; i < 7; i++) begin
            n_done = 0;
            cyc(tbl[i].st, tbl[i].sp, tbl[i].per, tbl[i].ld, 0);
            period(tbl[i].periods);
            chk($sformatf("row%0d_count", i), int'(count), tbl[i].exp_cnt);
            chk($sformatf("row%0d_busy", i), int'(busy), int'(tbl[i].exp_busy));
            chk($sformatf("row%0d_dones", i), n_done, tbl[i].exp_dones);
        end

        n_done = 0;
        cyc(1, 0, 0, 1, 0);
        repeat (S + 1) cyc(0, 0, 0, 0, 1);
        chk("pre_restart_tick", int'(tick), 1);
        cyc(1, 0, 0, 7, 1);
        chk("restart_count", int'(count), 7);
        repeat (6) cyc(0, 0, 0, 0, 1);
        repeat (10) cyc(0, 0, 0, 0, 0);
        chk("restart_count_hold", int'(count), 7);
        chk("restart_no_done", n_done, 0);

        cyc(1, 0, 0, 6, 0);
        period(2);
        chk("pre_reset_count", int'(count), 4);
        #2 reset = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk("async_tick", int'(tick), 0);
        rst_v = 0;
        repeat (2) cyc(0, 0, 0, 0, 0);
        rst_v = 1;
        n_done = 0;
        period(2);
        chk("post_reset_count", int'(count), 0);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_no_done", n_done, 0);

        sl = 0; ph_left = 6;
        repeat (600) begin
            if (ph_left == 0) begin sl = ~sl; ph_left = $urandom_range(S + 2, 12); end
            ph_left--;
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 5), sl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
